// File: rtl/one_detector.sv
// rtl/one_detector.sv - 16-bit bidirectional priority encoder with optional registered outputs
//
// Purpose:
//   Finds the lowest (i_order = 1) or highest (i_order = 0) set bit of i_code.
//   It reports that bit's index, flags an all-zero code, and returns the code
//   with the found bit cleared. Feeding o_rest back into i_code walks a
//   register list one set bit at a time.
//
// Build option:
//   ONE_DETECTOR_REG_EN  defined   -> the *_q outputs are flops with 1-cycle latency.
//                        undefined -> the *_q outputs are wired to the
//                                     combinational results, and i_clk/i_rst_n
//                                     are unused.
//
// Ports:
//   i_clk      clock, used only by the registered stage
//   i_rst_n    asynchronous active-low reset for the registered stage
//   i_code     16-bit vector to search
//   i_order    1 = lowest set bit, 0 = highest set bit
//   o_index    combinational index of the found bit
//   o_zero     combinational all-zero flag
//   o_rest     combinational i_code with the found bit cleared
//   o_index_q  registered o_index (reset value 0)
//   o_zero_q   registered o_zero  (reset value 1)
//   o_rest_q   registered o_rest  (reset value 0)

module one_detector (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_code,
    input  logic        i_order,
    output logic [3:0]  o_index,
    output logic        o_zero,
    output logic [15:0] o_rest,
    output logic [3:0]  o_index_q,
    output logic        o_zero_q,
    output logic [15:0] o_rest_q
);

    logic [3:0] found_index;

    // The scan direction is chosen so that the last match written wins:
    // scanning down keeps the lowest set bit, and scanning up keeps the
    // highest. For an all-zero code the loop never matches, so the default
    // (15 or 0) survives.
    always_comb begin
        found_index = i_order ? 4'd15 : 4'd0;
        if (i_order) begin
            for (int i = 15; i >= 0; i--) begin
                if (i_code[i]) begin
                    found_index = 4'(i);
                end
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (i_code[i]) begin
                    found_index = 4'(i);
                end
            end
        end
    end

    assign o_index = found_index;
    assign o_zero  = (i_code == 16'h0000);
    // For a zero code, masking still yields zero, so no special case is needed.
    assign o_rest  = i_code & ~(16'h0001 << found_index);

`ifdef ONE_DETECTOR_REG_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_index_q <= 4'd0;
            o_zero_q  <= 1'b1;
            o_rest_q  <= 16'h0000;
        end else begin
            o_index_q <= o_index;
            o_zero_q  <= o_zero;
            o_rest_q  <= o_rest;
        end
    end
`else
    // The clock and reset are kept as ports so callers see one footprint in both builds.
    logic unused_clk_rst;
    assign unused_clk_rst = i_clk ^ i_rst_n;

    assign o_index_q = o_index;
    assign o_zero_q  = o_zero;
    assign o_rest_q  = o_rest;
`endif

endmodule

// File: tb/tb_one_detector.sv
// tb/tb_one_detector.sv - self-checking bench for one_detector

module tb_one_detector;

    logic        i_clk;
    logic        i_rst_n;
    logic [15:0] i_code;
    logic        i_order;
    logic [3:0]  o_index;
    logic        o_zero;
    logic [15:0] o_rest;
    logic [3:0]  o_index_q;
    logic        o_zero_q;
    logic [15:0] o_rest_q;

    int errors = 0;
    int checks = 0;

    logic [3:0]  prev_idx;
    logic        prev_zero;
    logic [15:0] prev_rest;

    typedef struct {
        logic [15:0] code;
        logic        order;
        logic [3:0]  idx;
        logic        zero;
        logic [15:0] rest;
    } vec_t;

    vec_t tbl [10];

    one_detector dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_code    (i_code),
        .i_order   (i_order),
        .o_index   (o_index),
        .o_zero    (o_zero),
        .o_rest    (o_rest),
        .o_index_q (o_index_q),
        .o_zero_q  (o_zero_q),
        .o_rest_q  (o_rest_q)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model built from arithmetic identities, not from a bit scan:
    // c & -c isolates the lowest set bit, and clog2(c+1)-1 is the position
    // of the highest set bit.
    function automatic void model(input logic [15:0] c, input logic o,
                                  output logic [3:0] idx, output logic z,
                                  output logic [15:0] r);
        int low;
        if (c == 16'h0000) begin
            idx = o ? 4'd15 : 4'd0;
            z   = 1'b1;
            r   = 16'h0000;
        end else if (o) begin
            low = int'(c) & (-int'(c));
            idx = 4'($clog2(low));
            z   = 1'b0;
            r   = c ^ 16'(low);
        end else begin
            idx = 4'($clog2(int'(c) + 1) - 1);
            z   = 1'b0;
            r   = c ^ (16'h0001 << idx);
        end
    endfunction

    task automatic check_q(input string nm, input logic [3:0] ei, input logic ez, input logic [15:0] er);
        chk({nm, ".index_q"}, 32'(o_index_q), 32'(ei));
        chk({nm, ".zero_q"},  32'(o_zero_q),  32'(ez));
        chk({nm, ".rest_q"},  32'(o_rest_q),  32'(er));
    endtask

    // This task is called just after a falling edge and returns on the next one.
    task automatic apply(input logic [15:0] c, input logic o, input string nm,
                         input logic [3:0] ei, input logic ez, input logic [15:0] er);
        i_code  = c;
        i_order = o;
        #1;
        chk({nm, ".index"}, 32'(o_index), 32'(ei));
        chk({nm, ".zero"},  32'(o_zero),  32'(ez));
        chk({nm, ".rest"},  32'(o_rest),  32'(er));
`ifdef ONE_DETECTOR_REG_EN
        check_q({nm, ".pre"}, prev_idx, prev_zero, prev_rest);
`else
        check_q({nm, ".pre"}, ei, ez, er);
`endif
        @(posedge i_clk);
        #1;
        check_q({nm, ".post"}, ei, ez, er);
        prev_idx  = ei;
        prev_zero = ez;
        prev_rest = er;
        @(negedge i_clk);
    endtask

    task automatic apply_model(input logic [15:0] c, input logic o, input string nm);
        logic [3:0]  ei;
        logic        ez;
        logic [15:0] er;
        model(c, o, ei, ez, er);
        apply(c, o, nm, ei, ez, er);
    endtask

    initial begin
        logic [15:0] walk;
        logic        ord;

        tbl[0] = '{16'h0000, 1'b1, 4'd15, 1'b1, 16'h0000};
        tbl[1] = '{16'h0000, 1'b0, 4'd0,  1'b1, 16'h0000};
        tbl[2] = '{16'h0A30, 1'b1, 4'd4,  1'b0, 16'h0A20};
        tbl[3] = '{16'h0A30, 1'b0, 4'd11, 1'b0, 16'h0230};
        tbl[4] = '{16'h8001, 1'b0, 4'd15, 1'b0, 16'h0001};
        tbl[5] = '{16'h8001, 1'b1, 4'd0,  1'b0, 16'h8000};
        tbl[6] = '{16'h0020, 1'b1, 4'd5,  1'b0, 16'h0000};
        tbl[7] = '{16'h0020, 1'b0, 4'd5,  1'b0, 16'h0000};
        tbl[8] = '{16'hFFFF, 1'b0, 4'd15, 1'b0, 16'h7FFF};
        tbl[9] = '{16'hFFFF, 1'b1, 4'd0,  1'b0, 16'hFFFE};

        i_rst_n = 1'b0;
        i_code  = 16'h0000;
        i_order = 1'b1;
        #1;
`ifdef ONE_DETECTOR_REG_EN
        check_q("reset", 4'd0, 1'b1, 16'h0000);
`else
        check_q("reset", 4'd15, 1'b1, 16'h0000);
`endif
        @(negedge i_clk);
        i_rst_n   = 1'b1;
        prev_idx  = 4'd0;
        prev_zero = 1'b1;
        prev_rest = 16'h0000;

        for (int k = 0; k < 10; k++) begin
            apply(tbl[k].code, tbl[k].order, $sformatf("tbl%0d", k),
                  tbl[k].idx, tbl[k].zero, tbl[k].rest);
        end

        // Walk the list by feeding o_rest back into i_code.
        walk = 16'hFFFF;
        for (int s = 0; s < 16; s++) begin
            i_code = walk;
            i_order = 1'b1;
            #1;
            walk = o_rest;
            apply(i_code, 1'b1, $sformatf("walk%0d", s), 4'(s), 1'b0,
                  16'hFFFF << (s + 1));
        end
        i_code = walk;
        #1;
        chk("walk.end_zero", 32'(o_zero), 32'd1);
        @(negedge i_clk);

        // Hold reset low mid-cycle: the flops must clear without a clock edge.
        apply(16'h0400, 1'b0, "reg", 4'd10, 1'b0, 16'h0000);
        #2;
        i_rst_n = 1'b0;
        #1;
`ifdef ONE_DETECTOR_REG_EN
        check_q("rst_async", 4'd0, 1'b1, 16'h0000);
`else
        check_q("rst_async", 4'd10, 1'b0, 16'h0000);
`endif
        chk("rst_comb_index", 32'(o_index), 32'd10);
        @(negedge i_clk);
`ifdef ONE_DETECTOR_REG_EN
        check_q("rst_hold", 4'd0, 1'b1, 16'h0000);
`else
        check_q("rst_hold", 4'd10, 1'b0, 16'h0000);
`endif
        i_rst_n   = 1'b1;
        prev_idx  = 4'd0;
        prev_zero = 1'b1;
        prev_rest = 16'h0000;

        ord = 1'b1;
        for (int n = 0; n < 200; n++) begin
            logic [15:0] c;
            if (n % 10 == 0) ord = ~ord;
            c = 16'($urandom);
            case ($urandom_range(0, 7))
                0: c = 16'h0000;
                1: c = 16'h0001 << $urandom_range(0, 15);
                2: c = c & 16'($urandom);
                default: ;
            endcase
            apply_model(c, ord, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
